axi4_lite_reg_slice: RTL
========================

Name: axi4_lite_reg_slice

Overview:
- Timing-isolation slice inserted between the picorv32_axi master port and the AXI4-Lite memory/MMIO model.
- Registers every channel (AW, W, B, AR, R) through a 2-entry skid buffer, so that no combinational path from valid to ready, or from ready to valid, crosses the slice.
- Sustains one transfer per cycle per channel and adds exactly one cycle of forward latency on each registered channel.

Parameters:
- REG_AW, 1: 1 = skid-buffer the AW channel, 0 = pure wires.
- REG_W, 1: same, for the W channel.
- REG_B, 1: same, for the B channel.
- REG_AR, 1: same, for the AR channel.
- REG_R, 1: same, for the R channel.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_axi_awvalid/awready/awaddr/awprot  in/out/in/in  1/1/32/3  upstream write-address channel.
- cpu_axi_wvalid/wready/wdata/wstrb  in/out/in/in  1/1/32/4  upstream write-data channel.
- cpu_axi_bvalid/bready  out/in  1/1  upstream write response (no resp field).
- cpu_axi_arvalid/arready/araddr/arprot  in/out/in/in  1/1/32/3  upstream read-address channel.
- cpu_axi_rvalid/rready/rdata  out/in/out  1/1/32  upstream read data (no resp field).
- mem_axi_aw*, mem_axi_w*, mem_axi_ar*  out/in  same widths  downstream copies of the forward channels; valid and payload are outputs, ready is an input.
- mem_axi_bvalid/bready, mem_axi_rvalid/rready/rdata  in/out  same widths  downstream copies of the reverse channels; valid and payload are inputs, ready is an output.

Behaviour:
- One identical skid unit per channel, carrying the payload {addr,prot}, {data,strb}, {} or {data}.
- Unit state: out_valid, out_payload (main register); skid_valid, skid_payload (overflow register); in_ready (registered).
- Reset (reset=1 at a rising edge):
  - out_valid=0, skid_valid=0, in_ready=0.
  - All payload registers are cleared to 0.
  - in_ready rises to 1 at the first rising edge with reset=0.
  - Reset asserted mid-operation discards all buffered beats, with no replay. The surrounding system resets master and slave together.
- Upstream accept: a beat is accepted when in_valid && in_ready.
  - It goes to the main register if !out_valid, or if out_valid && out_ready (simultaneous drain).
  - Otherwise it goes to the skid register and skid_valid=1.
- Downstream drain: when out_valid && out_ready:
  - If skid_valid=1, the skid register moves into main and skid_valid=0.
  - Otherwise, main is refilled by a simultaneous accept, or out_valid=0.
- in_ready(next) = !skid_valid(next). It is never combinationally dependent on out_ready.
- Stability: once out_valid=1, out_payload holds constant until out_ready is sampled 1. out_valid never deasserts without a handshake.
- Latency:
  - A beat accepted at edge N appears on out_valid at N+1.
  - With downstream permanently ready, throughput is 1 beat/cycle and the skid stays empty.
- Ordering: strict FIFO per channel. Channels are independent; AW and W are neither paired nor reordered. B/R ordering is preserved.
- Capacity: at most 2 beats per channel. A third beat sees in_ready=0 until a drain.
- REG_x=0: that channel is a wire connection (out=in, ready passes back) with zero latency and no state.
- No address decode, no protocol checking, and no modification of prot/strb.

Test Plan:
- Reset release: hold reset 5 cycles -> every valid output is 0 and every ready output is 0 throughout; all readies are 1 one cycle after reset falls.
- Streaming read: 8 back-to-back AR beats (addresses 0x0,0x4,...,0x1C) with mem arready=1 -> each appears at mem_axi_araddr exactly 1 cycle later, no bubbles, cpu_axi_arready stays 1.
- Backpressure fill: mem awready=0, push AW 0x100 then 0x104 -> cpu_awready drops after the second beat; 0x100 is held stable; releasing awready delivers 0x100 then 0x104 on consecutive cycles; cpu_awready returns to 1.
- Simultaneous accept/drain: out_valid=1, out_ready=1 and an input beat in the same cycle -> main register is replaced with the new beat and skid_valid remains 0.
- Write path: AW 0x1000_0000 plus W data 0x41, strb 0001, with randomised readies on both sides (xorshift64 pattern) -> memory sees the write once with correct strb; B returns to the CPU exactly once.
- Reset mid-operation: skid full on R with rdata 0xDEADBEEF, then assert reset -> cpu_rvalid=0 on the next cycle and the beat is never delivered.

Source files
------------

// File: rtl/axi4_lite_reg_slice.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_reg_slice
// Brief    : AXI4-Lite timing-isolation slice with a 2-entry skid buffer
//            on each of the AW, W, B, AR and R channels.
// Revision : 1.0
// ============================================================================

module axi4_lite_reg_slice_skid #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_payload,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_payload
);
    logic         r_out_valid_q,   w_out_valid_d;
    logic [W-1:0] r_out_payload_q, w_out_payload_d;
    logic         r_skid_valid_q,  w_skid_valid_d;
    logic [W-1:0] r_skid_payload_q, w_skid_payload_d;
    logic         r_in_ready_q,    w_in_ready_d;
    logic         w_accept;
    logic         w_drain;

    assign w_accept = i_valid && r_in_ready_q;
    assign w_drain  = r_out_valid_q && i_ready;

    // o_ready is low whenever skid is full, so accept and skid-to-main never coincide
    always_comb begin
        w_out_valid_d    = r_out_valid_q;
        w_out_payload_d  = r_out_payload_q;
        w_skid_valid_d   = r_skid_valid_q;
        w_skid_payload_d = r_skid_payload_q;
        if (w_drain) begin
            if (r_skid_valid_q) begin
                w_out_payload_d = r_skid_payload_q;
                w_skid_valid_d  = 1'b0;
            end else if (w_accept) begin
                w_out_payload_d = i_payload;
            end else begin
                w_out_valid_d = 1'b0;
            end
        end else if (w_accept) begin
            if (r_out_valid_q) begin
                w_skid_valid_d   = 1'b1;
                w_skid_payload_d = i_payload;
            end else begin
                w_out_valid_d   = 1'b1;
                w_out_payload_d = i_payload;
            end
        end
        w_in_ready_d = !w_skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid_q    <= 1'b0;
            r_out_payload_q  <= '0;
            r_skid_valid_q   <= 1'b0;
            r_skid_payload_q <= '0;
            r_in_ready_q     <= 1'b0;
        end else begin
            r_out_valid_q    <= w_out_valid_d;
            r_out_payload_q  <= w_out_payload_d;
            r_skid_valid_q   <= w_skid_valid_d;
            r_skid_payload_q <= w_skid_payload_d;
            r_in_ready_q     <= w_in_ready_d;
        end
    end

    assign o_ready   = r_in_ready_q;
    assign o_valid   = r_out_valid_q;
    assign o_payload = r_out_payload_q;
endmodule

module axi4_lite_reg_slice #(
    parameter int REG_AW = 1,
    parameter int REG_W  = 1,
    parameter int REG_B  = 1,
    parameter int REG_AR = 1,
    parameter int REG_R  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_axi_awvalid,
    output logic        cpu_axi_awready,
    input  logic [31:0] cpu_axi_awaddr,
    input  logic [2:0]  cpu_axi_awprot,
    input  logic        cpu_axi_wvalid,
    output logic        cpu_axi_wready,
    input  logic [31:0] cpu_axi_wdata,
    input  logic [3:0]  cpu_axi_wstrb,
    output logic        cpu_axi_bvalid,
    input  logic        cpu_axi_bready,
    input  logic        cpu_axi_arvalid,
    output logic        cpu_axi_arready,
    input  logic [31:0] cpu_axi_araddr,
    input  logic [2:0]  cpu_axi_arprot,
    output logic        cpu_axi_rvalid,
    input  logic        cpu_axi_rready,
    output logic [31:0] cpu_axi_rdata,
    output logic        mem_axi_awvalid,
    input  logic        mem_axi_awready,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,
    output logic        mem_axi_wvalid,
    input  logic        mem_axi_wready,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,
    input  logic        mem_axi_bvalid,
    output logic        mem_axi_bready,
    output logic        mem_axi_arvalid,
    input  logic        mem_axi_arready,
    output logic [31:0] mem_axi_araddr,
    output logic [2:0]  mem_axi_arprot,
    input  logic        mem_axi_rvalid,
    output logic        mem_axi_rready,
    input  logic [31:0] mem_axi_rdata
);
    generate
        if (REG_AW != 0) begin : g_aw_reg
            axi4_lite_reg_slice_skid #(.W(35)) u_skid (
                .clk(clk), .reset(reset),
                .i_valid(cpu_axi_awvalid), .o_ready(cpu_axi_awready),
                .i_payload({cpu_axi_awaddr, cpu_axi_awprot}),
                .o_valid(mem_axi_awvalid), .i_ready(mem_axi_awready),
                .o_payload({mem_axi_awaddr, mem_axi_awprot})
            );
        end else begin : g_aw_wire
            assign mem_axi_awvalid = cpu_axi_awvalid;
            assign cpu_axi_awready = mem_axi_awready;
            assign mem_axi_awaddr  = cpu_axi_awaddr;
            assign mem_axi_awprot  = cpu_axi_awprot;
        end

        if (REG_W != 0) begin : g_w_reg
            axi4_lite_reg_slice_skid #(.W(36)) u_skid (
                .clk(clk), .reset(reset),
                .i_valid(cpu_axi_wvalid), .o_ready(cpu_axi_wready),
                .i_payload({cpu_axi_wdata, cpu_axi_wstrb}),
                .o_valid(mem_axi_wvalid), .i_ready(mem_axi_wready),
                .o_payload({mem_axi_wdata, mem_axi_wstrb})
            );
        end else begin : g_w_wire
            assign mem_axi_wvalid = cpu_axi_wvalid;
            assign cpu_axi_wready = mem_axi_wready;
            assign mem_axi_wdata  = cpu_axi_wdata;
            assign mem_axi_wstrb  = cpu_axi_wstrb;
        end

        // B carries no payload; a constant bit keeps the shared skid unit reusable
        if (REG_B != 0) begin : g_b_reg
            logic w_b_payload_unused;
            axi4_lite_reg_slice_skid #(.W(1)) u_skid (
                .clk(clk), .reset(reset),
                .i_valid(mem_axi_bvalid), .o_ready(mem_axi_bready),
                .i_payload(1'b0),
                .o_valid(cpu_axi_bvalid), .i_ready(cpu_axi_bready),
                .o_payload(w_b_payload_unused)
            );
        end else begin : g_b_wire
            assign cpu_axi_bvalid = mem_axi_bvalid;
            assign mem_axi_bready = cpu_axi_bready;
        end

        if (REG_AR != 0) begin : g_ar_reg
            axi4_lite_reg_slice_skid #(.W(35)) u_skid (
                .clk(clk), .reset(reset),
                .i_valid(cpu_axi_arvalid), .o_ready(cpu_axi_arready),
                .i_payload({cpu_axi_araddr, cpu_axi_arprot}),
                .o_valid(mem_axi_arvalid), .i_ready(mem_axi_arready),
                .o_payload({mem_axi_araddr, mem_axi_arprot})
            );
        end else begin : g_ar_wire
            assign mem_axi_arvalid = cpu_axi_arvalid;
            assign cpu_axi_arready = mem_axi_arready;
            assign mem_axi_araddr  = cpu_axi_araddr;
            assign mem_axi_arprot  = cpu_axi_arprot;
        end

        if (REG_R != 0) begin : g_r_reg
            axi4_lite_reg_slice_skid #(.W(32)) u_skid (
                .clk(clk), .reset(reset),
                .i_valid(mem_axi_rvalid), .o_ready(mem_axi_rready),
                .i_payload(mem_axi_rdata),
                .o_valid(cpu_axi_rvalid), .i_ready(cpu_axi_rready),
                .o_payload(cpu_axi_rdata)
            );
        end else begin : g_r_wire
            assign cpu_axi_rvalid = mem_axi_rvalid;
            assign mem_axi_rready = cpu_axi_rready;
            assign cpu_axi_rdata  = mem_axi_rdata;
        end
    endgenerate
endmodule
`default_nettype wire
